// File: rtl/stream_mux_nx1_if.sv
// ---------------------------------------------------------------------------
// stream_mux_nx1_if
// Bundles the handshake and data signals of the N-to-1 stream multiplexer.
//
// Handshake rule (all ports): a beat moves on a rising clock edge exactly
// when valid and ready are both 1 in that cycle. A producer holding valid
// keeps its data stable until the beat moves.
//
// Signals:
//   in_data   packed channel data, channel i at [i*DATAWIDTH +: DATAWIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel ready (driven by the mux)
//   sel       explicit channel select (explicit-select mode only)
//   out_data  registered output data
//   out_chan  index of the channel that supplied out_data
//   out_valid output register holds a beat
//   out_ready consumer accepts the beat
//   in_last / out_last  packet end markers, only with STREAM_MUX_LOCK_EN
//
// Modports: master = producer/consumer side, slave = the mux itself.
// ---------------------------------------------------------------------------
interface stream_mux_nx1_if #(
   parameter int DATAWIDTH = 64,
   parameter int CHANNELS  = 4,
   parameter int SELWIDTH  = 2
);
   logic [CHANNELS*DATAWIDTH-1:0] in_data;
   logic [CHANNELS-1:0]           in_valid;
   logic [CHANNELS-1:0]           in_ready;
   logic [SELWIDTH-1:0]           sel;
   logic [DATAWIDTH-1:0]          out_data;
   logic [SELWIDTH-1:0]           out_chan;
   logic                          out_valid;
   logic                          out_ready;
`ifdef STREAM_MUX_LOCK_EN
   logic [CHANNELS-1:0]           in_last;
   logic                          out_last;

   modport master (
      output in_data, in_valid, sel, out_ready, in_last,
      input  in_ready, out_data, out_chan, out_valid, out_last
   );
   modport slave (
      input  in_data, in_valid, sel, out_ready, in_last,
      output in_ready, out_data, out_chan, out_valid, out_last
   );
`else
   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );
   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
`endif
endinterface

// File: rtl/stream_mux_nx1.sv
// ---------------------------------------------------------------------------
// stream_mux_nx1
// N-channel registered stream multiplexer. One input channel is granted per
// cycle (explicit select in MODE 0, round-robin in MODE 1) and its beat is
// captured into a single output register. Full throughput: the output
// register can drain and reload in the same cycle.
//
// Ports:
//   Clk  rising-edge clock
//   Rst  synchronous reset, active-low
//   bus  stream_mux_nx1_if.slave (in_data/in_valid/in_ready/sel,
//        out_data/out_chan/out_valid/out_ready, optional in_last/out_last)
//
// Optional feature macro: STREAM_MUX_LOCK_EN
//   Adds in_last/out_last. After a beat with in_last=0 the grant stays locked
//   to that channel until a beat with in_last=1, keeping packets contiguous.
// ---------------------------------------------------------------------------
module stream_mux_nx1 #(
   parameter int DATAWIDTH = 64,
   parameter int CHANNELS  = 4,
   parameter int SELWIDTH  = 2,
   parameter int MODE      = 0
) (
   input logic             Clk,
   input logic             Rst,
   stream_mux_nx1_if.slave bus
);

   // Output register
   logic [DATAWIDTH-1:0] out_data_q;
   logic [SELWIDTH-1:0]  out_chan_q;
   logic                 out_valid_q;

   // Round-robin pointer: last granted channel
   logic [SELWIDTH-1:0]  rr_ptr;
   logic [SELWIDTH-1:0]  rr_grant;
   logic                 rr_found;

   logic [SELWIDTH-1:0]  grant;
   logic                 grant_ok;
   logic                 grant_valid;
   logic [DATAWIDTH-1:0] grant_data;
   logic [CHANNELS-1:0]  ready_vec;
   logic                 load_ok;
   logic                 xfer;

`ifdef STREAM_MUX_LOCK_EN
   logic                 lock_q;
   logic [SELWIDTH-1:0]  lock_chan;
   logic                 grant_last;
   logic                 out_last_q;
`endif

   assign load_ok = !out_valid_q || bus.out_ready;

   // Round-robin search starting after rr_ptr. Loop indices are constants so
   // every channel bit is addressed statically.
   always_comb begin
      rr_found = 1'b0;
      rr_grant = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!rr_found && (((int'(rr_ptr) + k) % CHANNELS) == i) && bus.in_valid[i]) begin
               rr_found = 1'b1;
               rr_grant = SELWIDTH'(i);
            end
         end
      end
   end

   // Grant decision; an active packet lock overrides select and arbitration.
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      if (MODE == 0) begin
         if (int'(bus.sel) < CHANNELS) begin
            grant    = bus.sel;
            grant_ok = 1'b1;
         end
      end else begin
         grant    = rr_grant;
         grant_ok = rr_found;
      end
`ifdef STREAM_MUX_LOCK_EN
      if (lock_q) begin
         grant    = lock_chan;
         grant_ok = 1'b1;
      end
`endif
   end

   // Granted channel's data/valid and the per-channel ready vector.
   always_comb begin
      ready_vec   = '0;
      grant_data  = '0;
      grant_valid = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
      grant_last  = 1'b0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(grant) == i) begin
            grant_data   = bus.in_data[i*DATAWIDTH +: DATAWIDTH];
            grant_valid  = bus.in_valid[i];
            ready_vec[i] = Rst && grant_ok && load_ok;
`ifdef STREAM_MUX_LOCK_EN
            grant_last   = bus.in_last[i];
`endif
         end
      end
   end

   assign xfer = Rst && grant_ok && load_ok && grant_valid;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         rr_ptr      <= SELWIDTH'(CHANNELS - 1);
`ifdef STREAM_MUX_LOCK_EN
         lock_q      <= 1'b0;
         lock_chan   <= '0;
         out_last_q  <= 1'b0;
`endif
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         out_data_q  <= grant_data;
         out_chan_q  <= grant;
         if (MODE != 0) begin
            rr_ptr <= grant;
         end
`ifdef STREAM_MUX_LOCK_EN
         lock_q      <= !grant_last;
         lock_chan   <= grant;
         out_last_q  <= grant_last;
`endif
      end else if (out_valid_q && bus.out_ready) begin
         // Drain only; data, channel and last flag keep their values.
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = ready_vec;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.out_valid = out_valid_q;
`ifdef STREAM_MUX_LOCK_EN
   assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_nx1.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_nx1
// Directed bench for stream_mux_nx1: one explicit-select instance (MODE 0,
// SELWIDTH 3 so an out-of-range select can be driven) and one round-robin
// instance (MODE 1). Inputs change 1 ns after a rising edge; registered
// outputs are checked 1 ns after the edge, combinational ready 1 ns after
// inputs change.
// ---------------------------------------------------------------------------
module tb_stream_mux_nx1;
   localparam int DW = 64;
   localparam int CH = 4;

   // Clock / reset
   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   stream_mux_nx1_if #(.DATAWIDTH(DW), .CHANNELS(CH), .SELWIDTH(3)) if_sel ();
   stream_mux_nx1_if #(.DATAWIDTH(DW), .CHANNELS(CH), .SELWIDTH(2)) if_rr ();

   stream_mux_nx1 #(.DATAWIDTH(DW), .CHANNELS(CH), .SELWIDTH(3), .MODE(0)) u_sel (
      .Clk (Clk),
      .Rst (Rst),
      .bus (if_sel.slave)
   );

   stream_mux_nx1 #(.DATAWIDTH(DW), .CHANNELS(CH), .SELWIDTH(2), .MODE(1)) u_rr (
      .Clk (Clk),
      .Rst (Rst),
      .bus (if_rr.slave)
   );

   // Scoreboard
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] e;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      Rst              = 1'b0;
      if_sel.in_data   = '0;
      if_sel.in_valid  = '1;
      if_sel.sel       = '0;
      if_sel.out_ready = 1'b0;
      if_rr.in_data    = {64'h103, 64'h102, 64'h101, 64'h100};
      if_rr.in_valid   = '1;
      if_rr.sel        = '0;
      if_rr.out_ready  = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
      if_sel.in_last   = '1;
      if_rr.in_last    = '1;
`endif

      // Reset with every channel requesting
      tick();
      tick();
      check_eq("rst_sel_valid", 64'(if_sel.out_valid), 64'd0);
      check_eq("rst_sel_data",  if_sel.out_data,       64'd0);
      check_eq("rst_sel_chan",  64'(if_sel.out_chan),  64'd0);
      check_eq("rst_sel_ready", 64'(if_sel.in_ready),  64'd0);
      check_eq("rst_rr_valid",  64'(if_rr.out_valid),  64'd0);
      check_eq("rst_rr_ready",  64'(if_rr.in_ready),   64'd0);

      // Explicit select: channel 2
      Rst = 1'b1;
      if_sel.sel = 3'd2;
      if_sel.in_data[2*DW +: DW] = 64'hA5;
      if_sel.out_ready = 1'b1;
      if_rr.in_valid = '0;
      if_rr.out_ready = 1'b1;
      settle();
      check_eq("sel2_ready", 64'(if_sel.in_ready), 64'b0100);
      check_eq("rr_idle_ready", 64'(if_rr.in_ready), 64'b0000);
      tick();
      check_eq("sel2_valid", 64'(if_sel.out_valid), 64'd1);
      check_eq("sel2_data",  if_sel.out_data,       64'hA5);
      check_eq("sel2_chan",  64'(if_sel.out_chan),  64'd2);
      check_eq("rr_idle_valid", 64'(if_rr.out_valid), 64'd0);

      // Out-of-range select: no grant, output drains
      if_sel.sel = 3'd5;
      settle();
      check_eq("sel5_ready", 64'(if_sel.in_ready), 64'b0000);
      tick();
      check_eq("sel5_valid", 64'(if_sel.out_valid), 64'd0);
      check_eq("sel5_data_hold", if_sel.out_data, 64'hA5);
      check_eq("sel5_chan_hold", 64'(if_sel.out_chan), 64'd2);

      // Load 0x1234 from channel 1
      if_sel.sel = 3'd1;
      if_sel.in_data[1*DW +: DW] = 64'h1234;
      settle();
      check_eq("sel1_ready", 64'(if_sel.in_ready), 64'b0010);
      tick();
      check_eq("sel1_data", if_sel.out_data, 64'h1234);
      check_eq("sel1_chan", 64'(if_sel.out_chan), 64'd1);

      // Backpressure for 3 cycles while channel 3 waits
      if_sel.out_ready = 1'b0;
      if_sel.sel = 3'd3;
      if_sel.in_data[3*DW +: DW] = 64'h5678;
      settle();
      check_eq("bp_ready0", 64'(if_sel.in_ready), 64'b0000);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("bp_hold_valid", 64'(if_sel.out_valid), 64'd1);
         check_eq("bp_hold_data",  if_sel.out_data,       64'h1234);
         check_eq("bp_hold_chan",  64'(if_sel.out_chan),  64'd1);
         check_eq("bp_ready",      64'(if_sel.in_ready),  64'b0000);
      end
      if_sel.out_ready = 1'b1;
      settle();
      check_eq("bp_release_ready", 64'(if_sel.in_ready), 64'b1000);
      tick();
      check_eq("bp_next_valid", 64'(if_sel.out_valid), 64'd1);
      check_eq("bp_next_data",  if_sel.out_data,       64'h5678);
      check_eq("bp_next_chan",  64'(if_sel.out_chan),  64'd3);
      if_sel.in_valid = '0;

      // Round-robin fairness, all channels requesting
      if_rr.in_valid = 4'b1111;
      settle();
      check_eq("rr_first_ready", 64'(if_rr.in_ready), 64'b0001);
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd1);
      exp_q.push_back(64'd2);
      exp_q.push_back(64'd3);
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd1);
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check_eq("rr_all_valid", 64'(if_rr.out_valid), 64'd1);
         check_eq("rr_all_chan",  64'(if_rr.out_chan),  e);
         check_eq("rr_all_data",  if_rr.out_data,       64'h100 + e);
      end

      // Sparse requests: channels 1 and 3, pointer now at 1
      if_rr.in_valid = 4'b1010;
      settle();
      check_eq("rr_sparse_ready", 64'(if_rr.in_ready), 64'b1000);
      exp_q.push_back(64'd3);
      exp_q.push_back(64'd1);
      exp_q.push_back(64'd3);
      exp_q.push_back(64'd1);
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check_eq("rr_sparse_valid", 64'(if_rr.out_valid), 64'd1);
         check_eq("rr_sparse_chan",  64'(if_rr.out_chan),  e);
      end

      // Single requester is granted every cycle
      if_rr.in_valid = 4'b1000;
      for (int c = 0; c < 3; c++) begin
         settle();
         check_eq("rr_single_ready", 64'(if_rr.in_ready), 64'b1000);
         tick();
         check_eq("rr_single_valid", 64'(if_rr.out_valid), 64'd1);
         check_eq("rr_single_chan",  64'(if_rr.out_chan),  64'd3);
      end
      if_rr.in_valid = '0;
      tick();
      check_eq("rr_drain_valid", 64'(if_rr.out_valid), 64'd0);

`ifdef STREAM_MUX_LOCK_EN
      // Packet lock: ch0 sends 3 beats, ch1 competes throughout
      if_rr.in_valid = 4'b0011;
      if_rr.in_last  = 4'b0000;
      settle();
      check_eq("lock_first_ready", 64'(if_rr.in_ready), 64'b0001);
      tick();
      check_eq("lock_b1_chan", 64'(if_rr.out_chan), 64'd0);
      check_eq("lock_b1_last", 64'(if_rr.out_last), 64'd0);
      // ch0 idle for a cycle: ch1 still blocked
      if_rr.in_valid = 4'b0010;
      settle();
      check_eq("lock_idle_ready", 64'(if_rr.in_ready), 64'b0001);
      tick();
      check_eq("lock_idle_valid", 64'(if_rr.out_valid), 64'd0);
      if_rr.in_valid = 4'b0011;
      tick();
      check_eq("lock_b2_chan", 64'(if_rr.out_chan), 64'd0);
      check_eq("lock_b2_last", 64'(if_rr.out_last), 64'd0);
      if_rr.in_last = 4'b0001;
      tick();
      check_eq("lock_b3_chan", 64'(if_rr.out_chan), 64'd0);
      check_eq("lock_b3_last", 64'(if_rr.out_last), 64'd1);
      tick();
      check_eq("lock_next_chan", 64'(if_rr.out_chan), 64'd1);
      check_eq("lock_next_last", 64'(if_rr.out_last), 64'd0);
      if_rr.in_valid = '0;
`endif

      // Final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
